// File: rtl/weight_rd_sched_if.sv
// Weight-read scheduler handshake bundle: layer control, loader tile handshake,
// and weight-RAM read port. master = scheduler side, slave = environment side.
interface weight_rd_sched_if #(
    parameter int AW = 16
);
    logic          start;
    logic          buf_ready;
    logic          rd_ready;
    logic          busy;
    logic          done;
    logic          buf_release;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic          rd_last;
    logic [AW-1:0] tile_idx;
    logic [AW-1:0] rep_idx;

    modport master (
        input  start, buf_ready, rd_ready,
        output busy, done, buf_release, rd_en, rd_addr, rd_valid, rd_last,
               tile_idx, rep_idx
    );

    modport slave (
        output start, buf_ready, rd_ready,
        input  busy, done, buf_release, rd_en, rd_addr, rd_valid, rd_last,
               tile_idx, rep_idx
    );
endinterface

// File: rtl/weight_rd_sched.sv
// Weight-buffer read sequencer: TILE_NUM tiles x REPEAT passes x TILE_SIZE words.
// rd_en is combinational on rd_ready in READ (stalls hold addr/rep); rd_valid trails rd_en by 1.
module weight_rd_sched #(
    parameter int AW        = 16,
    parameter int TILE_SIZE = 64,
    parameter int REPEAT    = 4,
    parameter int TILE_NUM  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_rst,
    weight_rd_sched_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUF = 3'd1,
        READ     = 3'd2,
        RELEASE  = 3'd3,
        FIN      = 3'd4
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = AW'(TILE_SIZE - 1);
    localparam logic [AW-1:0] REP_MAX  = AW'(REPEAT - 1);
    localparam logic [AW-1:0] TILE_MAX = AW'(TILE_NUM - 1);

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] rep;
    logic [AW-1:0] tile;
    logic          busy_q;
    logic          done_q;
    logic          rel_q;
    logic          rd_valid_q;
    logic          rd_en;

    assign rd_en = (state == READ) && bus.rd_ready;

    // busy/done/buf_release are registered alongside the state so they line up with it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            rep        <= '0;
            tile       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rel_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (sys_rst) begin
            state      <= IDLE;
            addr       <= '0;
            rep        <= '0;
            tile       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rel_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rel_q      <= 1'b0;
            rd_valid_q <= rd_en;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= WAIT_BUF;
                        busy_q <= 1'b1;
                    end
                end
                WAIT_BUF: begin
                    if (bus.buf_ready) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        if (addr == ADDR_MAX) begin
                            addr <= '0;
                            if (rep == REP_MAX) begin
                                rep   <= '0;
                                state <= RELEASE;
                                rel_q <= 1'b1;
                            end else begin
                                rep <= rep + 1'b1;
                            end
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (tile == TILE_MAX) begin
                        tile   <= '0;
                        state  <= FIN;
                        done_q <= 1'b1;
                    end else begin
                        tile  <= tile + 1'b1;
                        state <= WAIT_BUF;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.buf_release = rel_q;
    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = addr;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_last     = rd_en && (addr == ADDR_MAX);
    assign bus.tile_idx    = tile;
    assign bus.rep_idx     = rep;
endmodule

// File: tb/tb_weight_rd_sched.sv
// Scoreboard bench: stimulus queues expected reads/releases/done with relative cycle stamps,
// negedge monitors pop and compare whenever the DUTs present an event.
module tb_weight_rd_sched;
    typedef struct {
        int cyc;
        int addr;
        int tile;
        int rep;
        bit last;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sys_rst = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   busy_cnt = 0;
    int   last_cnt = 0;
    bit   prev_en = 1'b0;

    rd_t rd_q[$];
    int  rel_q[$];
    int  done_q[$];
    rd_t q1_rd[$];
    int  q1_rel[$];
    int  q1_done[$];
    rd_t e0;
    rd_t e1;
    int  v0;
    int  v1;

    weight_rd_sched_if #(.AW(16)) if0 ();
    weight_rd_sched_if #(.AW(16)) if1 ();

    weight_rd_sched #(.AW(16), .TILE_SIZE(4), .REPEAT(2), .TILE_NUM(3)) u0 (
        .clk(clk), .rst(rst), .sys_rst(sys_rst), .bus(if0)
    );
    weight_rd_sched #(.AW(16), .TILE_SIZE(4), .REPEAT(1), .TILE_NUM(1)) u1 (
        .clk(clk), .rst(rst), .sys_rst(sys_rst), .bus(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: got unexpected event expected none (t=%0t)", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - base < r) tick();
    endtask

    task automatic kick();
        if0.start = 1'b1;
        base = cyc;
        tick();
        if0.start = 1'b0;
    endtask

    // Expected traffic of the 4x2x3 layer: reads at off+2+10t+4r+a, release at off+10+10t, done at off+31.
    task automatic push_layer(input int off, input bit stamped, input int maxn);
        int  n;
        rd_t e;
        n = 0;
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < 2; r++) begin
                for (int a = 0; a < 4; a++) begin
                    if (n < maxn) begin
                        e.cyc  = stamped ? off + 2 + 10*t + 4*r + a : -1;
                        e.addr = a;
                        e.tile = t;
                        e.rep  = r;
                        e.last = (a == 3);
                        rd_q.push_back(e);
                    end
                    n++;
                end
            end
            if (n <= maxn) rel_q.push_back(stamped ? off + 10 + 10*t : -1);
        end
        if (n <= maxn) done_q.push_back(stamped ? off + 31 : -1);
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_rd_left"}, rd_q.size(), 0);
        chk({nm, "_rel_left"}, rel_q.size(), 0);
        chk({nm, "_done_left"}, done_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"}, int'(if0.busy), 0);
        chk({nm, "_done"}, int'(if0.done), 0);
        chk({nm, "_rel"}, int'(if0.buf_release), 0);
        chk({nm, "_rd_en"}, int'(if0.rd_en), 0);
        chk({nm, "_rd_addr"}, int'(if0.rd_addr), 0);
        chk({nm, "_rd_valid"}, int'(if0.rd_valid), 0);
        chk({nm, "_rd_last"}, int'(if0.rd_last), 0);
        chk({nm, "_tile"}, int'(if0.tile_idx), 0);
        chk({nm, "_rep"}, int'(if0.rep_idx), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            chk("rd_valid", int'(if0.rd_valid), int'(prev_en));
            prev_en = if0.rd_en && !sys_rst;
            if (if0.busy) busy_cnt++;
            if (if0.rd_en) begin
                if (if0.rd_last) last_cnt++;
                if (rd_q.size() == 0) fail("unexp_rd_en");
                else begin
                    e0 = rd_q.pop_front();
                    if (e0.cyc >= 0) chk("rd_cyc", cyc - base, e0.cyc);
                    chk("rd_addr", int'(if0.rd_addr), e0.addr);
                    chk("tile_idx", int'(if0.tile_idx), e0.tile);
                    chk("rep_idx", int'(if0.rep_idx), e0.rep);
                    chk("rd_last", int'(if0.rd_last), int'(e0.last));
                end
            end
            if (if0.buf_release) begin
                if (rel_q.size() == 0) fail("unexp_buf_release");
                else begin
                    v0 = rel_q.pop_front();
                    if (v0 >= 0) chk("rel_cyc", cyc - base, v0);
                end
            end
            if (if0.done) begin
                if (done_q.size() == 0) fail("unexp_done");
                else begin
                    v0 = done_q.pop_front();
                    if (v0 >= 0) chk("done_cyc", cyc - base, v0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (if1.rd_en) begin
                if (q1_rd.size() == 0) fail("u1_unexp_rd_en");
                else begin
                    e1 = q1_rd.pop_front();
                    chk("u1_rd_cyc", cyc - base, e1.cyc);
                    chk("u1_rd_addr", int'(if1.rd_addr), e1.addr);
                    chk("u1_rd_last", int'(if1.rd_last), int'(e1.last));
                end
            end
            if (if1.buf_release) begin
                if (q1_rel.size() == 0) fail("u1_unexp_rel");
                else begin
                    v1 = q1_rel.pop_front();
                    chk("u1_rel_cyc", cyc - base, v1);
                end
            end
            if (if1.done) begin
                if (q1_done.size() == 0) fail("u1_unexp_done");
                else begin
                    v1 = q1_done.pop_front();
                    chk("u1_done_cyc", cyc - base, v1);
                end
            end
        end
    end

    initial begin
        rd_t e;
        if0.start = 1'b0; if0.buf_ready = 1'b1; if0.rd_ready = 1'b1;
        if1.start = 1'b0; if1.buf_ready = 1'b1; if1.rd_ready = 1'b1;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Nominal layer; a second start while busy must be ignored.
        push_layer(0, 1'b1, 1000);
        busy_cnt = 0;
        kick();
        wait_rel(5);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        wait_rel(35);
        chk_empty("nominal");
        chk("busy_cycles", busy_cnt, 31);

        // rd_ready toggling every cycle.
        push_layer(0, 1'b0, 1000);
        last_cnt = 0;
        kick();
        for (int i = 0; i < 80; i++) begin
            if0.rd_ready = ~if0.rd_ready;
            tick();
        end
        if0.rd_ready = 1'b1;
        tick();
        tick();
        chk_empty("stall");
        chk("rd_last_count", last_cnt, 6);

        // Loader late by 5 cycles.
        push_layer(5, 1'b1, 1000);
        if0.buf_ready = 1'b0;
        kick();
        wait_rel(6);
        if0.buf_ready = 1'b1;
        wait_rel(40);
        chk_empty("late_buf");

        // Abort at tile 1, rep 1, addr 2.
        push_layer(0, 1'b1, 15);
        kick();
        wait_rel(18);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk_idle_outputs("abort");
        wait_rel(25);
        chk_empty("abort");

        // start coincident with sys_rst stays idle.
        if0.start = 1'b1;
        sys_rst = 1'b1;
        tick();
        if0.start = 1'b0;
        sys_rst = 1'b0;
        chk("start_vs_sys_rst_busy", int'(if0.busy), 0);
        tick();
        chk("start_vs_sys_rst_busy2", int'(if0.busy), 0);

        push_layer(0, 1'b1, 1000);
        kick();
        wait_rel(35);
        chk_empty("after_abort");

        // Async reset mid-READ, checked before any clock edge.
        push_layer(0, 1'b1, 3);
        kick();
        wait_rel(5);
        chk("pre_rst_rd_addr", int'(if0.rd_addr), 3);
        rst = 1'b1;
        #2;
        chk_idle_outputs("async_rst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_empty("async_rst");

        // Single-tile single-pass instance.
        for (int a = 0; a < 4; a++) begin
            e.cyc = 2 + a; e.addr = a; e.tile = 0; e.rep = 0; e.last = (a == 3);
            q1_rd.push_back(e);
        end
        q1_rel.push_back(6);
        q1_done.push_back(7);
        if1.start = 1'b1;
        base = cyc;
        tick();
        if1.start = 1'b0;
        wait_rel(10);
        chk("u1_rd_left", q1_rd.size(), 0);
        chk("u1_rel_left", q1_rel.size(), 0);
        chk("u1_done_left", q1_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
